pwm_update_sched: RTL and testbench

//  Timebase and update scheduler for a bank of NCH pwmOC output-compare channels.

---
 rtl/pwm_pkg.sv | 40 ++++
 rtl/pwm_timebase.sv | 30 +++
 rtl/pwm_update_sched.sv | 126 ++++++++++++
 tb/tb_pwm_update_sched.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared widths, types and compare-conversion helpers for the pwmOC update scheduler.
package pwm_pkg;

  localparam int unsigned WIDTH  = 17;
  localparam int unsigned HRBITS = 3;
  localparam int unsigned TBW    = WIDTH - HRBITS - 1;
  localparam int unsigned CW     = WIDTH - 1;

  typedef logic [TBW-1:0] tb_t;
  typedef logic [CW-1:0]  cmp_t;

  typedef enum logic {
    ST_IDLE,
    ST_ARMED
  } commit_state_e;

  // One coarse tick expressed in HR units.
  localparam cmp_t HR_TICK = cmp_t'(2 ** HRBITS);

  function automatic cmp_t period_to_hr(tb_t period);
    return cmp_t'(period) << HRBITS;
  endfunction

  // Keeps at least one coarse tick of high and low time so rise and fall never share a tick.
  function automatic cmp_t duty_clamp(cmp_t duty, cmp_t phr);
    cmp_t hi;
    hi = phr - HR_TICK;
    if (duty < HR_TICK) return HR_TICK;
    if (duty > hi) return hi;
    return duty;
  endfunction

  function automatic cmp_t hr_wrap_add(cmp_t phase, cmp_t duty, cmp_t phr);
    logic [CW:0] sum;
    sum = {1'b0, phase} + {1'b0, duty};
    if (sum >= {1'b0, phr}) sum = sum - {1'b0, phr};
    return sum[CW-1:0];
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Shared coarse timebase: counts 0..period-1 while enabled and flags the last tick.
module pwm_timebase
  import pwm_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [TBW-1:0] period,
  output logic [TBW-1:0] tb,
  output logic           wrap
);

  tb_t tb_q, tb_d;

  assign wrap = en && (tb_q == period - tb_t'(1));
  assign tb   = tb_q;

  // NOTE: tb_d takes its hold value first, so no path through this block leaves it unassigned.
  always_comb begin
    tb_d = tb_q;
    if (en) tb_d = wrap ? '0 : tb_q + tb_t'(1);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tb_q <= '0;
    else     tb_q <= tb_d;
  end

endmodule

// File: rtl/pwm_update_sched.sv
// Timebase plus shadow/active compare banks for NCH pwmOC channels; batches apply atomically at wrap.
module pwm_update_sched
  import pwm_pkg::*;
#(
  parameter  int unsigned NCH        = 4,
  parameter  int unsigned PERIOD_RST = 100,
  localparam int unsigned CHW        = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [TBW-1:0]    period_in,
  input  logic              period_we,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CHW-1:0]    cfg_ch,
  input  logic [CW-1:0]     cfg_phase,
  input  logic [CW-1:0]     cfg_duty,
  input  logic              cfg_commit,
  output logic              cfg_err,
  output logic [TBW-1:0]    tb,
  output logic              wrap,
  output logic              pending,
  output logic [NCH*CW-1:0] cmpH,
  output logic [NCH*CW-1:0] cmpL
);

  localparam tb_t  PERIOD_RST_T = tb_t'(PERIOD_RST);
  localparam tb_t  PERIOD_MIN   = tb_t'(2);
  localparam cmp_t DUTY_RST     = cmp_t'(PERIOD_RST << (HRBITS - 1));

  commit_state_e state_q, state_d;
  tb_t           period_q;
  tb_t           period_sh_q, period_sh_d;
  cmp_t          phase_sh_q [NCH];
  cmp_t          duty_sh_q  [NCH];
  cmp_t          cmph_q     [NCH];
  cmp_t          cmpl_q     [NCH];
  cmp_t          cmpl_conv  [NCH];
  cmp_t          phr_sh;
  logic          err_q;
  logic          xfer;
  logic          wr_ok;
  logic          apply;

  pwm_timebase u_timebase (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .period (period_q),
    .tb     (tb),
    .wrap   (wrap)
  );

  // Validation and conversion both work against the shadow period, not the active one.
  assign phr_sh    = period_to_hr(period_sh_q);
  assign pending   = (state_q == ST_ARMED);
  assign cfg_ready = !pending;
  assign cfg_err   = err_q;
  assign xfer      = cfg_valid && cfg_ready;
  assign wr_ok     = (32'(cfg_ch) < NCH) && (cfg_phase < phr_sh);
  assign apply     = wrap && pending;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (xfer && cfg_commit) state_d = ST_ARMED;
      ST_ARMED: if (wrap) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    period_sh_d = period_sh_q;
    if (period_we) period_sh_d = (period_in < PERIOD_MIN) ? PERIOD_MIN : period_in;
  end

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      cmpl_conv[i] = hr_wrap_add(phase_sh_q[i], duty_clamp(duty_sh_q[i], phr_sh), phr_sh);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      err_q       <= 1'b0;
      period_q    <= PERIOD_RST_T;
      period_sh_q <= PERIOD_RST_T;
    end else begin
      state_q     <= state_d;
      err_q       <= xfer && !wr_ok;
      period_sh_q <= period_sh_d;
      if (apply) period_q <= period_sh_q;
    end
  end

  // NOTE: the banks are reset on purpose: a reset mid-batch must discard every shadow write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        phase_sh_q[i] <= '0;
        duty_sh_q[i]  <= DUTY_RST;
        cmph_q[i]     <= '0;
        cmpl_q[i]     <= DUTY_RST;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (xfer && wr_ok && (cfg_ch == CHW'(i))) begin
          phase_sh_q[i] <= cfg_phase;
          duty_sh_q[i]  <= cfg_duty;
        end
        if (apply) begin
          cmph_q[i] <= phase_sh_q[i];
          cmpl_q[i] <= cmpl_conv[i];
        end
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_pack
    assign cmpH[g*CW +: CW] = cmph_q[g];
    assign cmpL[g*CW +: CW] = cmpl_q[g];
  end

endmodule

// File: tb/tb_pwm_update_sched.sv
// Directed bench for pwm_update_sched: a per-cycle behavioural model plus hand-computed pins.
module tb_pwm_update_sched;
  import pwm_pkg::*;

  localparam int NCH = 4;
  localparam int CHW = 2;
  localparam int HR  = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en = 1'b0;
  logic [TBW-1:0]    period_in = '0;
  logic              period_we = 1'b0;
  logic              cfg_valid = 1'b0;
  logic [CHW-1:0]    cfg_ch = '0;
  logic [CW-1:0]     cfg_phase = '0;
  logic [CW-1:0]     cfg_duty = '0;
  logic              cfg_commit = 1'b0;
  logic              cfg_ready, cfg_err, wrap, pending;
  logic [TBW-1:0]    tb;
  logic [NCH*CW-1:0] cmpH, cmpL;
  logic              cfg_ready3, cfg_err3, wrap3, pending3;
  logic [TBW-1:0]    tb3;
  logic [3*CW-1:0]   cmpH3, cmpL3;

  always #5 clk = ~clk;

  pwm_update_sched #(.NCH(NCH), .PERIOD_RST(100)) u_dut (
    .clk(clk), .rst(rst), .en(en), .period_in(period_in), .period_we(period_we),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch), .cfg_phase(cfg_phase),
    .cfg_duty(cfg_duty), .cfg_commit(cfg_commit), .cfg_err(cfg_err), .tb(tb), .wrap(wrap),
    .pending(pending), .cmpH(cmpH), .cmpL(cmpL)
  );

  // Three-channel instance on the same inputs: channel index 3 is out of range here.
  pwm_update_sched #(.NCH(3), .PERIOD_RST(100)) u_dut3 (
    .clk(clk), .rst(rst), .en(en), .period_in(period_in), .period_we(period_we),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready3), .cfg_ch(cfg_ch), .cfg_phase(cfg_phase),
    .cfg_duty(cfg_duty), .cfg_commit(cfg_commit), .cfg_err(cfg_err3), .tb(tb3), .wrap(wrap3),
    .pending(pending3), .cmpH(cmpH3), .cmpL(cmpL3)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [CW-1:0] chv(logic [NCH*CW-1:0] v, int i);
    return v[i*CW +: CW];
  endfunction

  // Behavioural model, plain integers.
  int m_tb = 0, m_per = 100, m_per_sh = 100;
  bit m_pend = 0, m_err = 0, m_err3 = 0;
  int m_ph [NCH];
  int m_du [NCH];
  int m_h  [NCH];
  int m_l  [NCH];

  function automatic int conv_l(int ph, int du, int phr);
    int d, s;
    d = du;
    if (d < HR) d = HR;
    if (d > phr - HR) d = phr - HR;
    s = ph + d;
    if (s >= phr) s -= phr;
    return s;
  endfunction

  task automatic model_reset();
    m_tb = 0; m_per = 100; m_per_sh = 100;
    m_pend = 0; m_err = 0; m_err3 = 0;
    for (int i = 0; i < NCH; i++) begin
      m_ph[i] = 0; m_du[i] = 400; m_h[i] = 0; m_l[i] = 400;
    end
  endtask

  task automatic model_step();
    int phrs;
    bit mw, xf;
    phrs   = m_per_sh * HR;
    mw     = en && (m_tb == m_per - 1);
    xf     = cfg_valid && !m_pend;
    m_err  = xf && (int'(cfg_ch) >= NCH || int'(cfg_phase) >= phrs);
    m_err3 = xf && (int'(cfg_ch) >= 3 || int'(cfg_phase) >= phrs);
    if (mw && m_pend) begin
      m_per = m_per_sh;
      for (int i = 0; i < NCH; i++) begin
        m_h[i] = m_ph[i];
        m_l[i] = conv_l(m_ph[i], m_du[i], phrs);
      end
      m_pend = 0;
    end else if (xf && cfg_commit) begin
      m_pend = 1;
    end
    if (xf && !m_err) begin
      m_ph[cfg_ch] = int'(cfg_phase);
      m_du[cfg_ch] = int'(cfg_duty);
    end
    if (en) m_tb = mw ? 0 : m_tb + 1;
    if (period_we) m_per_sh = (int'(period_in) < 2) ? 2 : int'(period_in);
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else     model_step();
  end

  always @(negedge clk) begin
    check("tb", tb, m_tb);
    check("wrap", wrap, en && (m_tb == m_per - 1));
    check("pending", pending, m_pend);
    check("cfg_ready", cfg_ready, !m_pend);
    check("cfg_err", cfg_err, m_err);
    check("tb3", tb3, m_tb);
    check("wrap3", wrap3, en && (m_tb == m_per - 1));
    check("pending3", pending3, m_pend);
    check("cfg_ready3", cfg_ready3, !m_pend);
    check("cfg_err3", cfg_err3, m_err3);
    for (int i = 0; i < NCH; i++) begin
      check($sformatf("cmpH[%0d]", i), chv(cmpH, i), m_h[i]);
      check($sformatf("cmpL[%0d]", i), chv(cmpL, i), m_l[i]);
    end
    for (int i = 0; i < 3; i++) begin
      check($sformatf("cmpH3[%0d]", i), chv({16'h0, cmpH3}, i), m_h[i]);
      check($sformatf("cmpL3[%0d]", i), chv({16'h0, cmpL3}, i), m_l[i]);
    end
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_tb(int v);
    int n = 0;
    while (int'(tb) != v && n < 400) begin
      cyc(1);
      n++;
    end
    check($sformatf("reach_tb_%0d", v), tb, v);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (pending && n < 400) begin
      cyc(1);
      n++;
    end
    check("pending_clears", pending, 0);
  endtask

  task automatic do_write(int ch, int ph, int du, bit commit);
    int n = 0;
    cfg_ch = CHW'(ch); cfg_phase = CW'(ph); cfg_duty = CW'(du);
    cfg_commit = commit; cfg_valid = 1'b1;
    while (!cfg_ready && n < 400) begin
      cyc(1);
      n++;
    end
    if (!cfg_ready) check("xfer_ready", cfg_ready, 1);
    cyc(1);
    cfg_valid = 1'b0; cfg_commit = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // T1: reset values and free-running count
    repeat (3) @(posedge clk);
    #1; rst = 1'b0; en = 1'b1;
    #1;
    check("t1_tb", tb, 0);
    check("t1_ready", cfg_ready, 1);
    check("t1_pending", pending, 0);
    check("t1_err", cfg_err, 0);
    check("t1_cmpH0", chv(cmpH, 0), 0);
    check("t1_cmpL0", chv(cmpL, 0), 400);
    check("t1_cmpL3", chv(cmpL, 3), 400);
    wait_tb(99);
    check("t1_wrap_at_99", wrap, 1);
    cyc(1);
    check("t1_tb_wraps", tb, 0);

    // T2: single-channel commit at tb=10
    wait_tb(10);
    do_write(1, 80, 160, 1);
    check("t2_pending", pending, 1);
    check("t2_ready_low", cfg_ready, 0);
    check("t2_cmpH1_held", chv(cmpH, 1), 0);
    wait_tb(99);
    check("t2_cmpL1_held", chv(cmpL, 1), 400);
    check("t2_ready_low_wrap", cfg_ready, 0);
    cyc(1);
    check("t2_cmpH1", chv(cmpH, 1), 80);
    check("t2_cmpL1", chv(cmpL, 1), 240);
    check("t2_ready_back", cfg_ready, 1);

    // T3: wrap-around and duty clamps at PHR=800
    wait_tb(5);
    do_write(2, 700, 300, 0);
    do_write(0, 700, 0, 0);
    do_write(3, 700, 800, 1);
    wait_tb(0);
    check("t3_wrap_around", chv(cmpL, 2), 200);
    check("t3_duty_min", chv(cmpL, 0), 708);
    check("t3_duty_max", chv(cmpL, 3), 692);
    check("t3_cmpH3", chv(cmpH, 3), 700);
    check("t3_ch1_kept", chv(cmpL, 1), 240);

    // T5: rejected writes, rejected commit still arms, held valid
    wait_tb(5);
    do_write(2, 900, 10, 0);
    check("t5_err_phase", cfg_err, 1);
    cyc(1);
    check("t5_err_pulse_end", cfg_err, 0);
    do_write(2, 800, 10, 0);
    check("t5_err_phase_eq_phr", cfg_err, 1);
    do_write(2, 799, 10, 0);
    check("t5_phase_max_ok", cfg_err, 0);
    do_write(3, 100, 100, 0);
    check("t5_ch3_ok_nch4", cfg_err, 0);
    check("t5_ch3_err_nch3", cfg_err3, 1);
    do_write(2, 1000, 5, 1);
    check("t5_reject_err", cfg_err, 1);
    check("t5_reject_arms", pending, 1);
    do_write(1, 100, 100, 1);
    check("t5_held_accept_tb", tb, 1);
    check("t5_held_pending", pending, 1);
    check("t5_cmpH2", chv(cmpH, 2), 799);
    check("t5_cmpL2", chv(cmpL, 2), 9);
    check("t5_cmpL3", chv(cmpL, 3), 200);
    wait_tb(0);
    check("t5_cmpH1", chv(cmpH, 1), 100);
    check("t5_cmpL1", chv(cmpL, 1), 200);

    // T4: period change with commit, validation against the old shadow
    wait_tb(5);
    period_in = 13'd50; period_we = 1'b1;
    do_write(1, 600, 100, 1);
    period_we = 1'b0;
    check("t4_not_rejected", cfg_err, 0);
    wait_tb(99);
    check("t4_old_period_wrap", wrap, 1);
    cyc(1);
    check("t4_cmpH1", chv(cmpH, 1), 600);
    check("t4_cmpL1", chv(cmpL, 1), 300);
    wait_tb(49);
    check("t4_new_period_wrap", wrap, 1);
    cyc(1);
    check("t4_tb_zero", tb, 0);

    // period_we coinciding with the applying wrap; 1 is stored as 2
    do_write(0, 8, 16, 1);
    wait_tb(49);
    period_in = 13'd1; period_we = 1'b1;
    cyc(1);
    period_we = 1'b0;
    check("t4_apply_old_shadow", chv(cmpL, 0), 24);
    wait_tb(49);
    check("t4_period_still_50", wrap, 1);
    do_write(0, 8, 8, 1);
    wait_idle();
    check("t4_min_period_cmpL0", chv(cmpL, 0), 0);
    cyc(1);
    check("t4_period2_tb", tb, 1);
    check("t4_period2_wrap", wrap, 1);
    cyc(1);
    check("t4_period2_back", tb, 0);
    period_in = 13'd100; period_we = 1'b1;
    do_write(0, 0, 400, 1);
    period_we = 1'b0;
    wait_idle();
    check("t4_restore_cmpL0", chv(cmpL, 0), 400);
    wait_tb(99);
    check("t4_restore_wrap", wrap, 1);

    // en=0 holds tb, suppresses wrap and delays the commit
    do_write(3, 50, 60, 1);
    wait_tb(99);
    en = 1'b0;
    #1;
    check("en_low_no_wrap", wrap, 0);
    cyc(10);
    check("en_low_tb_hold", tb, 99);
    check("en_low_pending", pending, 1);
    check("en_low_cmpH3_held", chv(cmpH, 3), 100);
    en = 1'b1;
    #1;
    check("en_high_wrap", wrap, 1);
    cyc(1);
    check("en_apply_cmpH3", chv(cmpH, 3), 50);
    check("en_apply_cmpL3", chv(cmpL, 3), 110);

    // T6: reset while armed drops the batch
    wait_tb(20);
    do_write(1, 300, 300, 1);
    check("t6_armed", pending, 1);
    cyc(5);
    rst = 1'b1;
    #1;
    check("t6_rst_pending", pending, 0);
    check("t6_rst_tb", tb, 0);
    check("t6_rst_ready", cfg_ready, 1);
    check("t6_rst_cmpH1", chv(cmpH, 1), 0);
    check("t6_rst_cmpL1", chv(cmpL, 1), 400);
    check("t6_rst_cmpL3", chv(cmpL, 3), 400);
    cyc(2);
    rst = 1'b0;
    wait_tb(99);
    cyc(1);
    check("t6_dropped_cmpH1", chv(cmpH, 1), 0);
    check("t6_dropped_pending", pending, 0);
    wait_tb(5);
    do_write(0, 20, 100, 1);
    wait_idle();
    check("t6_shadow_cleared_H1", chv(cmpH, 1), 0);
    check("t6_shadow_cleared_L1", chv(cmpL, 1), 400);
    check("t6_new_cmpL0", chv(cmpL, 0), 120);
    check("t6_cmpH3_reset", chv(cmpH, 3), 0);

    cyc(3);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
